// File: rtl/interrupt_controller.sv
// Eight-line edge-triggered interrupt controller with fixed priority (line 0 highest),
// per-line masking and a single-level request/acknowledge/done handshake to the CPU.
module interrupt_controller #(
  parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  irq,
  input  logic [7:0]  mask_in,
  input  logic        mask_we,
  input  logic        int_enable,
  input  logic        int_ack,
  input  logic        int_done,
  output logic        int_req,
  output logic [15:0] vector_addr,
  output logic        in_service,
  output logic [7:0]  pending_out,
  output logic [7:0]  mask_out
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVICE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  irq_prev;
  logic [7:0]  irq_edge;
  logic [7:0]  pending;
  logic [7:0]  mask;
  logic [7:0]  eligible;
  logic [7:0]  pending_clear;
  logic [2:0]  winner;
  logic [2:0]  active_idx;
  logic [2:0]  active_idx_next;
  logic        int_req_next;
  logic        in_service_next;
  logic [15:0] vector_addr_next;
  logic [15:0] winner_vector;

  assign irq_edge      = irq & ~irq_prev;
  assign eligible      = pending & mask;
  assign winner_vector = VECTOR_BASE + {12'd0, winner, 1'b0};
  assign pending_out   = pending;
  assign mask_out      = mask;

  // Scan from the lowest-priority line upward so the lowest set index wins.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 3'(i);
      end
    end
  end

  always_comb begin
    state_next       = state;
    active_idx_next  = active_idx;
    int_req_next     = int_req;
    in_service_next  = in_service;
    vector_addr_next = vector_addr;
    pending_clear    = 8'h00;
    case (state)
      IDLE: begin
        if (int_enable && (eligible != 8'h00)) begin
          active_idx_next  = winner;
          int_req_next     = 1'b1;
          vector_addr_next = winner_vector;
          state_next       = REQUEST;
        end
      end
      REQUEST: begin
        if (int_ack) begin
          pending_clear   = 8'h01 << active_idx;
          int_req_next    = 1'b0;
          in_service_next = 1'b1;
          state_next      = SERVICE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          in_service_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      active_idx  <= 3'd0;
      int_req     <= 1'b0;
      in_service  <= 1'b0;
      vector_addr <= VECTOR_BASE;
    end else begin
      state       <= state_next;
      active_idx  <= active_idx_next;
      int_req     <= int_req_next;
      in_service  <= in_service_next;
      vector_addr <= vector_addr_next;
    end
  end

  // Set after clear, so a fresh edge arriving with the ack is kept as a new occurrence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev <= 8'hFF;
      pending  <= 8'h00;
      mask     <= 8'h00;
    end else begin
      irq_prev <= irq;
      pending  <= (pending & ~pending_clear) | irq_edge;
      if (mask_we) begin
        mask <= mask_in;
      end
    end
  end

endmodule
